// File: rtl/blink_pkg.sv
// Shared types and default timing constants for the board button path.
package blink_pkg;

    // Button FSM: idle, counting a press, held, counting a release.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // 20 ms settle time and 1 s long-press threshold at 50 MHz.
    localparam int KEY_DEBOUNCE_CYC = 1_000_000;
    localparam int KEY_LONG_CYC     = 50_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous board input.
// RESET_VAL lets each input reset to its own inactive level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; meta is never used outside this module.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Debounces one active-low pushbutton and produces a clean level plus
// single-cycle press, release and long-press pulses, all registered.
module key_debounce
    import blink_pkg::*;
#(
    parameter int DEBOUNCE_CYC = KEY_DEBOUNCE_CYC,
    parameter int LONG_CYC     = KEY_LONG_CYC
) (
    input  logic clk50m,
    input  logic reset,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam int DB_W = $clog2(DEBOUNCE_CYC);
    localparam int LG_W = $clog2(LONG_CYC);

    // The entry sample from IDLE/PRESSED counts as the first stable sample,
    // so the wait state finishes when its counter would step to DEBOUNCE_CYC-1.
    localparam logic [DB_W-1:0] DB_DONE = DB_W'(DEBOUNCE_CYC - 2);
    localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYC - 1);
    localparam logic [LG_W-1:0] LG_PRE  = LG_W'(LONG_CYC - 2);

    logic            sync_q;
    logic            pk;
    key_state_t      state;
    key_state_t      state_next;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_next;
    logic [LG_W-1:0] long_cnt;
    logic [LG_W-1:0] long_cnt_next;
    logic            level_next;
    logic            press_next;
    logic            release_next;
    logic            long_next;

    // Resets to released so leaving reset never looks like a press.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk50m),
        .reset (reset),
        .d     (key_n),
        .q     (sync_q)
    );

    assign pk = ~sync_q;

    // State and counter registers.
    always_ff @(posedge clk50m or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            db_cnt   <= '0;
            long_cnt <= '0;
        end else begin
            state    <= state_next;
            db_cnt   <= db_cnt_next;
            long_cnt <= long_cnt_next;
        end
    end

    // Next state and counters; any opposite sample aborts a wait.
    always_comb begin
        state_next    = state;
        db_cnt_next   = db_cnt;
        long_cnt_next = long_cnt;
        case (state)
            IDLE: begin
                if (pk) begin
                    state_next  = PRESS_WAIT;
                    db_cnt_next = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pk) begin
                    state_next  = IDLE;
                    db_cnt_next = '0;
                end else if (db_cnt == DB_DONE) begin
                    state_next    = PRESSED;
                    db_cnt_next   = '0;
                    long_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt + DB_W'(1);
                end
            end
            PRESSED: begin
                // Hold time keeps counting on the edge a release starts.
                if (long_cnt != LG_LAST) begin
                    long_cnt_next = long_cnt + LG_W'(1);
                end
                if (!pk) begin
                    state_next  = RELEASE_WAIT;
                    db_cnt_next = '0;
                end
            end
            RELEASE_WAIT: begin
                // long_cnt is frozen here so a glitch only delays the long press.
                if (pk) begin
                    state_next  = PRESSED;
                    db_cnt_next = '0;
                end else if (db_cnt == DB_DONE) begin
                    state_next    = IDLE;
                    db_cnt_next   = '0;
                    long_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt + DB_W'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                db_cnt_next   = '0;
                long_cnt_next = '0;
            end
        endcase
    end

    // Output decode; each pulse belongs to a different state, so they never overlap.
    always_comb begin
        press_next   = (state == PRESS_WAIT) && (state_next == PRESSED);
        release_next = (state == RELEASE_WAIT) && (state_next == IDLE);
        long_next    = (state == PRESSED) && (long_cnt == LG_PRE);
        level_next   = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
    end

    // Output registers, updated on the same edge as the state change.
    always_ff @(posedge clk50m or posedge reset) begin
        if (reset) begin
            key_level        <= 1'b0;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
        end else begin
            key_level        <= level_next;
            press_pulse      <= press_next;
            release_pulse    <= release_next;
            long_press_pulse <= long_next;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with short timing constants: directed scenarios
// plus random key activity, all checked against a run-length model.
module tb_key_debounce;

    localparam int DEB  = 8;
    localparam int LONG = 32;

    logic clk50m = 1'b0;
    logic reset  = 1'b0;
    logic key_n  = 1'b1;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;
    int cyc      = 0;

    key_debounce #(
        .DEBOUNCE_CYC (DEB),
        .LONG_CYC     (LONG)
    ) dut (
        .clk50m           (clk50m),
        .reset            (reset),
        .key_n            (key_n),
        .key_level        (key_level),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_press_pulse (long_press_pulse)
    );

    // ---------------- clock ----------------
    always #10 clk50m = ~clk50m;

    always @(posedge clk50m) cyc <= cyc + 1;

    // ---------------- checking helpers ----------------
    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The button is seen two edges late. An accepted level flips after DEB
    // consecutive edge samples disagree with it. Hold time counts edges where
    // the key is accepted pressed and no release run is in progress.
    logic m_h1 = 1'b1, m_h2 = 1'b1;
    logic m_level = 1'b0;
    int   m_run = 0, m_held = 0;
    logic exp_press = 1'b0, exp_release = 1'b0, exp_long = 1'b0;

    always @(posedge clk50m or posedge reset) begin
        logic pk;
        int   run, held;
        logic lvl, ep, er, el;
        if (reset) begin
            m_h1 <= 1'b1; m_h2 <= 1'b1; m_level <= 1'b0;
            m_run <= 0; m_held <= 0;
            exp_press <= 1'b0; exp_release <= 1'b0; exp_long <= 1'b0;
        end else begin
            pk = ~m_h2;
            run = m_run; held = m_held; lvl = m_level;
            ep = 1'b0; er = 1'b0; el = 1'b0;
            if (lvl && run == 0 && held < LONG - 1) begin
                held++;
                if (held == LONG - 1) el = 1'b1;
            end
            if (pk != lvl) begin
                run++;
                if (run == DEB) begin
                    lvl = pk; run = 0; held = 0;
                    if (pk) ep = 1'b1; else er = 1'b1;
                end
            end else begin
                run = 0;
            end
            m_h2 <= m_h1; m_h1 <= key_n;
            m_run <= run; m_held <= held; m_level <= lvl;
            exp_press <= ep; exp_release <= er; exp_long <= el;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk50m) begin
        if (chk_on) begin
            check_bit("key_level", key_level, m_level);
            check_bit("press_pulse", press_pulse, exp_press);
            check_bit("release_pulse", release_pulse, exp_release);
            check_bit("long_press_pulse", long_press_pulse, exp_long);
        end
    end

    // ---------------- event monitor for literal expectations ----------------
    int press_cnt = 0, rel_cnt = 0, long_cnt = 0, fall_cnt = 0;
    int press_at = -1, rel_at = -1, long_at = -1, rise_at = -1, fall_at = -1;
    logic prev_level = 1'b0;

    always @(negedge clk50m) begin
        if (press_pulse)      begin press_cnt++; press_at = cyc; end
        if (release_pulse)    begin rel_cnt++;   rel_at   = cyc; end
        if (long_press_pulse) begin long_cnt++;  long_at  = cyc; end
        if (key_level && !prev_level) rise_at = cyc;
        if (!key_level && prev_level) begin fall_cnt++; fall_at = cyc; end
        prev_level = key_level;
    end

    task automatic clear_events();
        press_cnt = 0; rel_cnt = 0; long_cnt = 0; fall_cnt = 0;
        press_at = -1; rel_at = -1; long_at = -1; rise_at = -1; fall_at = -1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic hold(input int n);
        repeat (n) @(negedge clk50m);
    endtask

    task automatic reset_pulse(input int n);
        reset = 1'b1;
        hold(n);
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t0, t1, tr;

        // Reset / idle
        @(negedge clk50m);
        reset = 1'b1;
        chk_on = 1'b1;
        hold(3);
        reset = 1'b0;
        clear_events();
        hold(50);
        check_int("idle press count", press_cnt, 0);
        check_int("idle release count", rel_cnt, 0);
        check_int("idle long count", long_cnt, 0);
        check_bit("idle key_level", key_level, 1'b0);

        // Clean press and release
        clear_events();
        key_n = 1'b0; t0 = cyc;
        hold(20);
        key_n = 1'b1; t1 = cyc;
        hold(20);
        check_int("clean press count", press_cnt, 1);
        check_int("clean press latency", press_at - t0, 10);
        check_int("clean level rise", rise_at - t0, 10);
        check_int("clean release count", rel_cnt, 1);
        check_int("clean release latency", rel_at - t1, 10);
        check_int("clean level fall", fall_at - t1, 10);

        // Bounce
        clear_events();
        for (int i = 0; i < 10; i++) begin
            key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            hold(3);
        end
        check_int("bounce press during toggle", press_cnt, 0);
        check_int("bounce release during toggle", rel_cnt, 0);
        key_n = 1'b0; t0 = cyc;
        hold(20);
        check_int("bounce press count", press_cnt, 1);
        check_int("bounce press latency", press_at - t0, 10);
        key_n = 1'b1;
        hold(20);

        // Long press
        clear_events();
        key_n = 1'b0; t0 = cyc;
        hold(60);
        check_int("long press latency", press_at - t0, 10);
        check_int("long pulse count", long_cnt, 1);
        check_int("long pulse cycle", long_at - t0, 41);
        key_n = 1'b1;
        hold(20);
        check_int("long release count", rel_cnt, 1);

        // Release glitch while pressed
        clear_events();
        key_n = 1'b0; t0 = cyc;
        hold(15);
        key_n = 1'b1;
        hold(4);
        key_n = 1'b0;
        hold(51);
        check_int("glitch release count", rel_cnt, 0);
        check_int("glitch level drops", fall_cnt, 0);
        check_int("glitch long count", long_cnt, 1);
        check_int("glitch long cycle", long_at - t0, 45);
        key_n = 1'b1;
        hold(20);

        // Reset mid-press
        clear_events();
        key_n = 1'b0; t0 = cyc;
        hold(15);
        reset = 1'b1;
        #1;
        check_bit("reset clears key_level", key_level, 1'b0);
        check_bit("reset clears long pulse", long_press_pulse, 1'b0);
        @(negedge clk50m);
        reset = 1'b0; tr = cyc;
        hold(20);
        check_int("reset press count", press_cnt, 2);
        check_int("reset re-press latency", press_at - tr, 10);
        check_int("reset no release", rel_cnt, 0);
        key_n = 1'b1;
        hold(20);

        // Random key activity, with an occasional reset
        for (int i = 0; i < 200; i++) begin
            key_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) hold($urandom_range(9, 45));
            else hold($urandom_range(1, 10));
            if ($urandom_range(0, 60) == 0) reset_pulse($urandom_range(1, 3));
        end
        key_n = 1'b1;
        hold(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
